// File: rtl/sci_acc_dispatch.sv
// Packet FIFO feeding round-robin compute lanes, with results returned in acceptance order.
// Optional SCI_ACC_DROP_CNT_EN adds a saturating 16-bit drop_cnt output.
module sci_acc_dispatch #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_MODES  = 4,
    parameter int RES_WIDTH  = 8,
    parameter int NUM_LANES  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pkt_valid,
    input  logic [DATA_WIDTH-1:0]           op_pkt__data,
    input  logic [NUM_MODES-1:0]            op_pkt__mode,
    input  logic [RES_WIDTH-1:0]            op_pkt__res,
    output logic                            ready,
    output logic                            pkt_dropd,
    output logic [NUM_LANES-1:0]            lane_start,
    output logic [DATA_WIDTH-1:0]           lane_data,
    output logic [NUM_MODES-1:0]            lane_mode,
    output logic [RES_WIDTH-1:0]            lane_res,
    input  logic [NUM_LANES-1:0]            lane_done,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_result,
    output logic [NUM_LANES-1:0]            busy_lanes,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            done
`ifdef SCI_ACC_DROP_CNT_EN
    ,
    output logic [15:0]                     drop_cnt
`endif
);

    localparam int LW = $clog2(NUM_LANES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = LW + 1;

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [NUM_MODES-1:0]  fifo_mode [FIFO_DEPTH];
    logic [RES_WIDTH-1:0]  fifo_res  [FIFO_DEPTH];
    logic [AW-1:0]         fifo_wr, fifo_rd;
    logic [CW-1:0]         fifo_cnt;

    logic [LW-1:0]         oq_mem [NUM_LANES];
    logic [LW-1:0]         oq_wr, oq_rd, oq_head;
    logic [OW-1:0]         oq_cnt;

    logic [DATA_WIDTH-1:0] res_buf [NUM_LANES];
    logic [NUM_LANES-1:0]  res_vld;
    logic [LW-1:0]         rr_ptr;

    logic                  accept, drop, disp, disp_hit, deliver;
    logic [LW-1:0]         disp_lane;
    int unsigned           cand;

    function automatic logic [LW-1:0] lane_inc(input logic [LW-1:0] v);
        return (v == LW'(NUM_LANES - 1)) ? '0 : v + 1'b1;
    endfunction

    assign ready   = (fifo_cnt < CW'(FIFO_DEPTH));
    assign accept  = pkt_valid && ready && $onehot(op_pkt__mode);
    assign drop    = pkt_valid && !accept;
    assign disp    = (fifo_cnt != '0) && disp_hit;
    assign oq_head = oq_mem[oq_rd];
    assign deliver = (oq_cnt != '0) && res_vld[oq_head];

    // First idle lane at or above rr_ptr, wrapping at NUM_LANES (not necessarily a power of 2).
    always_comb begin
        disp_hit  = 1'b0;
        disp_lane = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            cand = 32'(rr_ptr) + i;
            if (cand >= NUM_LANES)
                cand = cand - NUM_LANES;
            if (!disp_hit && !busy_lanes[LW'(cand)]) begin
                disp_hit  = 1'b1;
                disp_lane = LW'(cand);
            end
        end
    end

    // Storage arrays carry no reset; their validity is tracked by the pointers and res_vld.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            fifo_data[fifo_wr] <= op_pkt__data;
            fifo_mode[fifo_wr] <= op_pkt__mode;
            fifo_res[fifo_wr]  <= op_pkt__res;
        end
        if (disp && !rst)
            oq_mem[oq_wr] <= disp_lane;
        for (int unsigned l = 0; l < NUM_LANES; l++)
            if (lane_done[l] && busy_lanes[l] && !res_vld[l])
                res_buf[l] <= lane_result[l*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            fifo_cnt   <= '0;
            oq_wr      <= '0;
            oq_rd      <= '0;
            oq_cnt     <= '0;
            rr_ptr     <= '0;
            res_vld    <= '0;
            busy_lanes <= '0;
            lane_start <= '0;
            pkt_dropd  <= 1'b0;
            done       <= 1'b0;
            data_out   <= '0;
            lane_data  <= '0;
            lane_mode  <= '0;
            lane_res   <= '0;
        end else begin
            pkt_dropd  <= drop;
            lane_start <= '0;
            done       <= deliver;
            if (accept)
                fifo_wr <= fifo_wr + 1'b1;
            case ({accept, disp})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
            if (disp) begin
                fifo_rd               <= fifo_rd + 1'b1;
                lane_start[disp_lane] <= 1'b1;
                lane_data             <= fifo_data[fifo_rd];
                lane_mode             <= fifo_mode[fifo_rd];
                lane_res              <= fifo_res[fifo_rd];
                busy_lanes[disp_lane] <= 1'b1;
                oq_wr                 <= lane_inc(oq_wr);
                rr_ptr                <= lane_inc(disp_lane);
            end
            for (int unsigned l = 0; l < NUM_LANES; l++)
                if (lane_done[l] && busy_lanes[l] && !res_vld[l])
                    res_vld[l] <= 1'b1;
            // Head delivery is evaluated last; the head lane never matches the capture above.
            if (deliver) begin
                data_out            <= res_buf[oq_head];
                oq_rd               <= lane_inc(oq_rd);
                res_vld[oq_head]    <= 1'b0;
                busy_lanes[oq_head] <= 1'b0;
            end
            case ({disp, deliver})
                2'b10:   oq_cnt <= oq_cnt + 1'b1;
                2'b01:   oq_cnt <= oq_cnt - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef SCI_ACC_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= '0;
        else if (drop && drop_cnt != '1)
            drop_cnt <= drop_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_sci_acc_dispatch.sv
// Directed bench for sci_acc_dispatch: lane model plus in-order result scoreboard.
// Build with +define+SCI_ACC_DROP_CNT_EN to also check drop_cnt.
module tb_sci_acc_dispatch;

    localparam int DW = 32;
    localparam int NM = 4;
    localparam int RW = 8;
    localparam int NL = 4;
    localparam logic [31:0] K = 32'h5A5A_00BB;

    logic              clk, rst, pkt_valid;
    logic [DW-1:0]     op_pkt__data;
    logic [NM-1:0]     op_pkt__mode;
    logic [RW-1:0]     op_pkt__res;
    logic              ready, pkt_dropd, done;
    logic [NL-1:0]     lane_start, lane_done, busy_lanes;
    logic [DW-1:0]     lane_data, data_out;
    logic [NM-1:0]     lane_mode;
    logic [RW-1:0]     lane_res;
    logic [NL*DW-1:0]  lane_result;
`ifdef SCI_ACC_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    int            total = 0;
    int            bad = 0;
    logic [31:0]   exp_q[$];
    logic [NL-1:0] pending;
    logic [31:0]   lane_val [NL];
    logic [31:0]   mon_e;

    sci_acc_dispatch #(
        .DATA_WIDTH(DW), .NUM_MODES(NM), .RES_WIDTH(RW), .NUM_LANES(NL), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid),
        .op_pkt__data(op_pkt__data), .op_pkt__mode(op_pkt__mode), .op_pkt__res(op_pkt__res),
        .ready(ready), .pkt_dropd(pkt_dropd), .lane_start(lane_start),
        .lane_data(lane_data), .lane_mode(lane_mode), .lane_res(lane_res),
        .lane_done(lane_done), .lane_result(lane_result), .busy_lanes(busy_lanes),
        .data_out(data_out), .done(done)
`ifdef SCI_ACC_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] x, input logic [3:0] m, input logic push);
        pkt_valid    = 1'b1;
        op_pkt__data = x;
        op_pkt__mode = m;
        op_pkt__res  = x[7:0];
        if (push)
            exp_q.push_back(x ^ K);
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        pkt_valid = 1'b0;
        lane_done = '0;
        tick;
        tick;
        rst = 1'b0;
        exp_q.delete();
        pending = '0;
    endtask

    task automatic pulse_lane(input int l, input logic [31:0] r);
        lane_done               = NL'(1 << l);
        lane_result[l*DW +: DW] = r;
        tick;
        lane_done = '0;
    endtask

    // Lane model: every dispatched lane completes on the next cycle with lane_data ^ K.
    task automatic drain;
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            lane_done = pending;
            for (int l = 0; l < NL; l++)
                if (pending[l])
                    lane_result[l*DW +: DW] = lane_val[l] ^ K;
            pending = '0;
            tick;
            n++;
        end
        lane_done = '0;
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        tick;
        tick;
        chk("drain_busy", 32'(busy_lanes), 32'd0);
        chk("drain_ready", 32'(ready), 32'd1);
    endtask

    // Scoreboard pop on done; lane_start records dispatches for the lane model.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (exp_q.size() == 0)
                    chk("unexpected_done", 32'(done), 32'd0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("data_out", data_out, mon_e);
                end
            end
            if (lane_start != '0) begin
                chk("lane_start_onehot", 32'($onehot(lane_start)), 32'd1);
                for (int l = 0; l < NL; l++)
                    if (lane_start[l]) begin
                        pending[l]  = 1'b1;
                        lane_val[l] = lane_data;
                    end
            end
        end
    end

    initial begin
        pkt_valid    = 1'b0;
        op_pkt__data = '0;
        op_pkt__mode = '0;
        op_pkt__res  = '0;
        lane_done    = '0;
        lane_result  = '0;
        pending      = '0;
        do_reset;

        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy_lanes), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_lane_start", 32'(lane_start), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_dropd", 32'(pkt_dropd), 32'd0);

        // Single packet through lane 0
        send(32'h10, 4'b0001, 1'b0);
        exp_q.push_back(32'hAB);
        tick;
        pkt_valid = 1'b0;
        chk("s1_start_early", 32'(lane_start), 32'd0);
        tick;
        chk("s1_start", 32'(lane_start), 32'b0001);
        chk("s1_lane_data", lane_data, 32'h10);
        chk("s1_lane_mode", 32'(lane_mode), 32'b0001);
        chk("s1_lane_res", 32'(lane_res), 32'h10);
        chk("s1_busy", 32'(busy_lanes), 32'b0001);
        tick;
        chk("s1_start_pulse", 32'(lane_start), 32'd0);
        pulse_lane(0, 32'hAB);
        chk("s1_done_early", 32'(done), 32'd0);
        tick;
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_data_out", data_out, 32'hAB);
        tick;
        chk("s1_done_pulse", 32'(done), 32'd0);
        chk("s1_data_hold", data_out, 32'hAB);
        chk("s1_busy_clear", 32'(busy_lanes), 32'd0);
        pending = '0;

        // Four back-to-back packets, lanes finish in reverse order
        do_reset;
        for (int k = 0; k < 5; k++) begin
            if (k < 4)
                send(32'h100 + 32'(k), 4'b0010, 1'b1);
            else
                pkt_valid = 1'b0;
            tick;
            if (k >= 1) begin
                chk("s2_start", 32'(lane_start), 32'(1 << (k - 1)));
                chk("s2_lane_data", lane_data, 32'h100 + 32'(k - 1));
            end
        end
        chk("s2_busy_full", 32'(busy_lanes), 32'b1111);
        for (int l = 3; l >= 1; l--) begin
            pulse_lane(l, (32'h100 + 32'(l)) ^ K);
            chk("s2_no_done_a", 32'(done), 32'd0);
            tick;
            chk("s2_no_done_b", 32'(done), 32'd0);
        end
        pulse_lane(0, 32'h100 ^ K);
        chk("s2_head_early", 32'(done), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("s2_done", 32'(done), 32'd1);
            chk("s2_order", data_out, (32'h100 + 32'(k)) ^ K);
        end
        tick;
        chk("s2_done_end", 32'(done), 32'd0);
        chk("s2_busy_end", 32'(busy_lanes), 32'd0);
        pending = '0;

        // All lanes stalled: fill FIFO, overflow with the 9th packet
        do_reset;
        for (int k = 0; k < 4; k++) begin
            send(32'h200 + 32'(k), 4'b0100, 1'b1);
            tick;
        end
        pkt_valid = 1'b0;
        tick;
        chk("s3_busy_full", 32'(busy_lanes), 32'b1111);
        for (int k = 0; k < 9; k++) begin
            chk("s3_ready", 32'(ready), (k < 8) ? 32'd1 : 32'd0);
            send(32'h300 + 32'(k), 4'b1000, k < 8);
            tick;
            if (k == 7)
                chk("s3_no_drop", 32'(pkt_dropd), 32'd0);
        end
        pkt_valid = 1'b0;
        chk("s3_dropd", 32'(pkt_dropd), 32'd1);
`ifdef SCI_ACC_DROP_CNT_EN
        chk("s3_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        tick;
        chk("s3_dropd_pulse", 32'(pkt_dropd), 32'd0);
        drain;

        // Non-one-hot mode is discarded
        send(32'h3C, 4'b0011, 1'b0);
        tick;
        pkt_valid = 1'b0;
        chk("s4_dropd", 32'(pkt_dropd), 32'd1);
        chk("s4_ready", 32'(ready), 32'd1);
`ifdef SCI_ACC_DROP_CNT_EN
        chk("s4_drop_cnt", 32'(drop_cnt), 32'd2);
`endif
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("s4_no_start", 32'(lane_start), 32'd0);
            chk("s4_no_busy", 32'(busy_lanes), 32'd0);
        end

        // Reset with three lanes busy; packets during reset and stale completions ignored
        for (int k = 0; k < 3; k++) begin
            send(32'h400 + 32'(k), 4'b0001, 1'b1);
            tick;
        end
        pkt_valid = 1'b0;
        tick;
        chk("s5_three_busy", 32'($countones(busy_lanes)), 32'd3);
        rst = 1'b1;
        send(32'h999, 4'b0001, 1'b0);
        tick;
        tick;
        rst       = 1'b0;
        pkt_valid = 1'b0;
        exp_q.delete();
        pending = '0;
        chk("s5_busy", 32'(busy_lanes), 32'd0);
        chk("s5_ready", 32'(ready), 32'd1);
        chk("s5_done", 32'(done), 32'd0);
        chk("s5_data_out", data_out, 32'd0);
`ifdef SCI_ACC_DROP_CNT_EN
        chk("s5_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        lane_done   = 4'b0111;
        lane_result = {4{32'h777}};
        tick;
        lane_done = '0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("s5_stale_done", 32'(done), 32'd0);
            chk("s5_stale_busy", 32'(busy_lanes), 32'd0);
            chk("s5_stale_start", 32'(lane_start), 32'd0);
        end

        // Completion on an idle lane must not leave a stale result behind
        pulse_lane(2, 32'hDEAD);
        tick;
        tick;
        chk("s6_done", 32'(done), 32'd0);
        chk("s6_busy", 32'(busy_lanes), 32'd0);
        for (int k = 0; k < 3; k++) begin
            send(32'h500 + 32'(k), 4'b0100, 1'b1);
            tick;
        end
        pkt_valid = 1'b0;
        drain;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sci_acc_dispatch.md
SCI_ACC_DISPATCH -- requirements
Module: sci_acc_dispatch

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- DATA_WIDTH, 32, operand and result width.
- NUM_MODES, 4, one-hot mode field width.
- RES_WIDTH, 8, resolution field width.
- NUM_LANES, 4, number of compute lanes (2..8).
- FIFO_DEPTH, 8, input FIFO entries (power of 2, at least 2).
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, reset; synchronous, active-high.
- pkt_valid, in, 1, input packet strobe.
- op_pkt__data, in, DATA_WIDTH, operand x.
- op_pkt__mode, in, NUM_MODES, one-hot operation mode.
- op_pkt__res, in, RES_WIDTH, resolution.
- ready, out, 1, FIFO can accept a packet.
- pkt_dropd, out, 1, one-cycle pulse: a packet was discarded.
- lane_start, out, NUM_LANES, one-hot one-cycle dispatch pulse.
- lane_data, out, DATA_WIDTH, dispatched operand; valid with lane_start.
- lane_mode, out, NUM_MODES, dispatched mode; valid with lane_start.
- lane_res, out, RES_WIDTH, dispatched resolution; valid with lane_start.
- lane_done, in, NUM_LANES, per-lane completion pulse.
- lane_result, in, NUM_LANES*DATA_WIDTH, lane L result in bits [L*DATA_WIDTH +: DATA_WIDTH].
- busy_lanes, out, NUM_LANES, lane L is dispatched and its result is not yet delivered.
- data_out, out, DATA_WIDTH, in-order result.
- done, out, 1, one-cycle pulse: data_out is valid.

Function
REQ-003 ready SHALL equal (FIFO occupancy < FIFO_DEPTH), derived combinationally from registered state.
REQ-004 A packet SHALL be accepted when pkt_valid=1, ready=1 and op_pkt__mode has exactly one bit set. It SHALL be written into the FIFO at that clock edge.
REQ-005 When pkt_valid=1 and either ready=0 or the mode is not one-hot, the packet SHALL be discarded. pkt_dropd SHALL be 1 for exactly the following cycle.
REQ-006 Dispatch SHALL occur at most once per cycle, when the FIFO is non-empty and at least one lane is idle.
REQ-007 The chosen lane SHALL be the first idle lane found searching from rr_ptr upward, modulo NUM_LANES.
REQ-008 On dispatch to lane L, the following SHALL happen at the same edge:
- The FIFO head is popped.
- busy_lanes[L] is set.
- L is pushed to the order queue (depth NUM_LANES).
- rr_ptr becomes (L+1) mod NUM_LANES.
- lane_start[L], lane_data, lane_mode and lane_res are registered.
REQ-009 lane_start SHALL assert 2 cycles after acceptance when the FIFO was empty and a lane was idle.
REQ-010 lane_done[L] while busy_lanes[L]=1 SHALL capture lane_result slice L into res_buf[L] and set res_vld[L]. lane_done[L] on an idle lane SHALL be ignored.
REQ-011 When the order-queue head H has res_vld[H]=1, the block SHALL register data_out <= res_buf[H] and pulse done for one cycle. It SHALL pop the queue and clear res_vld[H] and busy_lanes[H].
REQ-012 done SHALL follow the head lane's lane_done by exactly 2 cycles. Non-head lanes that finish early SHALL wait: results leave strictly in acceptance order.
REQ-013 A lane freed at edge t SHALL be dispatchable at edge t+1.
REQ-014 A push and pop in the same cycle on a non-full FIFO SHALL both take effect. Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-015 data_out SHALL hold its last value between done pulses.

Reset
REQ-016 While rst=1 at an edge, the following SHALL be cleared:
- FIFO pointers and count, order queue, rr_ptr (to 0).
- res_vld, busy_lanes, lane_start, pkt_dropd, done.
- data_out, lane_data, lane_mode, lane_res (to 0).
REQ-017 After reset, ready SHALL be 1. Inputs presented during reset SHALL be ignored.
REQ-018 lane_done pulses for work dispatched before a mid-operation reset SHALL be ignored.

Configuration
REQ-019 SCI_ACC_DROP_CNT_EN defined: an extra output port drop_cnt (16 bits) SHALL count pkt_dropd events. It SHALL saturate at 0xFFFF and clear on rst.
REQ-020 SCI_ACC_DROP_CNT_EN undefined: the drop_cnt port and its logic SHALL be absent. All other behaviour SHALL be unchanged.

Verification
REQ-021 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Single packet x=0x10, mode=0001 -> lane_start=0001 two cycles later with lane_data=0x10; lane_done[0] with result 0xAB -> done=1, data_out=0xAB two cycles later.
- 4 packets back-to-back, lanes 3,2,1,0 finish in that order -> done pulses in order lanes 0,1,2,3; busy_lanes returns to 0000.
- 9 packets on consecutive cycles with all lanes stalled -> ready=0 after the 8th is stored; 9th gives pkt_dropd=1; drop_cnt=1 when the macro is defined.
- Packet with mode=0011 -> pkt_dropd=1, no lane_start.
- Reset asserted with 3 lanes busy, then stale lane_done pulses -> no done; busy_lanes=0; ready=1.
- lane_done[2] while lane 2 is idle -> no state change.
